// File: rtl/port_strobed_in.sv
// port_strobed_in: configurable-width input port for an 8255A-compatible
// peripheral.
//   mode 0 : simple sampled input; data_out follows the synchronised pins.
//   mode 1 : strobed handshake input (STB#/IBF/INTR) with a DEPTH-entry FIFO.
// Ports:
//   clk, reset_n        : system clock, asynchronous active-low reset
//   mode                : 0 = sampled, 1 = strobed handshake
//   port_in, stb_n      : external port data and peripheral strobe
//   rd_n                : CPU read strobe (pop on its rising edge)
//   inte, ovf_clr       : interrupt enable, synchronous overflow clear
//   data_out            : value presented to the CPU read mux
//   ibf, not_empty      : FIFO full / FIFO holds at least one entry
//   intr, count, ovf    : interrupt request, occupancy, sticky overflow
module port_strobed_in #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CW          = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             mode,
  input  logic [WIDTH-1:0] port_in,
  input  logic             stb_n,
  input  logic             rd_n,
  input  logic             inte,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] data_out,
  output logic             ibf,
  output logic             not_empty,
  output logic             intr,
  output logic [CW-1:0]    count,
  output logic             ovf
);

  localparam int            PW   = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [SYNC_STAGES-1:0] stb_sync_q, stb_sync_d;
  logic [SYNC_STAGES-1:0] rd_sync_q, rd_sync_d;
  logic [WIDTH-1:0]       pin_sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]       pin_sync_d [SYNC_STAGES];
  logic                   stb_dly_q, rd_dly_q;
  logic                   mode_q;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   ovf_q, ovf_d, intr_q, intr_d;
  logic [WIDTH-1:0]       data_out_q, data_out_d;
  logic [WIDTH-1:0]       mem_q [DEPTH];

  logic             stb_s, rd_s;
  logic [WIDTH-1:0] pin_s;
  logic             mode_chg, active, stb_fall, rd_rise;
  logic             full, push, pop_ok, push_ok, ovf_set;

  assign stb_s = stb_sync_q[SYNC_STAGES-1];
  assign rd_s  = rd_sync_q[SYNC_STAGES-1];
  assign pin_s = pin_sync_q[SYNC_STAGES-1];

  always_comb begin
    stb_sync_d    = {stb_sync_q[SYNC_STAGES-2:0], stb_n};
    rd_sync_d     = {rd_sync_q[SYNC_STAGES-2:0], rd_n};
    pin_sync_d[0] = port_in;
    for (int i = 1; i < SYNC_STAGES; i++) pin_sync_d[i] = pin_sync_q[i-1];
  end

  // A mode change discards any edge seen in the same cycle, so push/pop are
  // only honoured when the live mode and its registered copy are both 1.
  assign mode_chg = mode ^ mode_q;
  assign active   = mode & ~mode_chg;
  assign stb_fall = stb_dly_q & ~stb_s;
  assign rd_rise  = ~rd_dly_q & rd_s;
  assign full     = (count_q == FULL);
  assign push     = active & stb_fall;
  assign pop_ok   = active & rd_rise & (count_q != '0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok  = push & (~full | pop_ok);
  assign ovf_set  = push & full & ~pop_ok;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (mode_chg) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (mode_chg)     ovf_d = 1'b0;
    else if (ovf_set) ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  assign intr_d = ~mode_chg & inte & (count_q != '0) & stb_s & rd_s;

  // data_out is registered and must show the new head at the same edge the
  // FIFO state changes. If the entry being written is the new head, it is not
  // in memory yet, so bypass pin_s.
  always_comb begin
    data_out_d = data_out_q;
    if (!mode) begin
      data_out_d = pin_s;
    end else if (count_d != '0) begin
      if (push_ok && (count_d == ONE)) data_out_d = pin_s;
      else                             data_out_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stb_sync_q <= '1;
      rd_sync_q  <= '1;
      for (int i = 0; i < SYNC_STAGES; i++) pin_sync_q[i] <= '0;
      stb_dly_q  <= 1'b1;
      rd_dly_q   <= 1'b1;
      mode_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      intr_q     <= 1'b0;
      data_out_q <= '0;
    end else begin
      stb_sync_q <= stb_sync_d;
      rd_sync_q  <= rd_sync_d;
      pin_sync_q <= pin_sync_d;
      stb_dly_q  <= stb_s;
      rd_dly_q   <= rd_s;
      mode_q     <= mode;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      intr_q     <= intr_d;
      data_out_q <= data_out_d;
    end
  end

  // Storage needs no reset: count and pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= pin_s;
  end

  assign data_out  = data_out_q;
  assign ibf       = full;
  assign not_empty = (count_q != '0);
  assign intr      = intr_q;
  assign count     = count_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_port_strobed_in.sv
// Randomised scoreboard bench for port_strobed_in (WIDTH=8, DEPTH=4,
// SYNC_STAGES=2). A queue-based FIFO model predicts the data the CPU sees at
// the end of each read; a monitor compares it on every rd_n rising edge.
module tb_port_strobed_in;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int S  = 2;
  localparam int CW = $clog2(D + 1);

  logic          clk;
  logic          reset_n;
  logic          mode;
  logic [W-1:0]  port_in;
  logic          stb_n;
  logic          rd_n;
  logic          inte;
  logic          ovf_clr;
  logic [W-1:0]  data_out;
  logic          ibf;
  logic          not_empty;
  logic          intr;
  logic [CW-1:0] count;
  logic          ovf;

  port_strobed_in #(.WIDTH(W), .DEPTH(D), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset_n(reset_n), .mode(mode), .port_in(port_in),
    .stb_n(stb_n), .rd_n(rd_n), .inte(inte), .ovf_clr(ovf_clr),
    .data_out(data_out), .ibf(ibf), .not_empty(not_empty), .intr(intr),
    .count(count), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_err = 0;
  logic [W-1:0] model[$];
  logic [W-1:0] exp_q[$];
  logic         m_ovf = 1'b0;
  logic [W-1:0] last_val = '0;
  bit           mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string tag);
    check({tag, " count"},     32'(count),     32'(model.size()));
    check({tag, " ibf"},       32'(ibf),       32'(model.size() == D));
    check({tag, " not_empty"}, 32'(not_empty), 32'(model.size() != 0));
    check({tag, " ovf"},       32'(ovf),       32'(m_ovf));
    check({tag, " intr"},      32'(intr),      32'(inte && (model.size() != 0)));
  endtask

  task automatic do_push(input logic [W-1:0] d);
    port_in = d;
    stb_n = 1'b0;
    step(4);
    stb_n = 1'b1;
    step(4);
    if (model.size() < D) begin
      model.push_back(d);
      last_val = model[0];
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic do_read();
    rd_n = 1'b0;
    step(4);
    check("intr during read", 32'(intr), 32'd0);
    exp_q.push_back((model.size() != 0) ? model[0] : last_val);
    rd_n = 1'b1;
    step(4);
    if (model.size() != 0) begin
      void'(model.pop_front());
      if (model.size() != 0) last_val = model[0];
    end
  endtask

  // rd_n rises together with stb_n falling, so both edges land in the same
  // synchronised cycle.
  task automatic do_simul(input logic [W-1:0] d);
    port_in = d;
    rd_n = 1'b0;
    step(4);
    exp_q.push_back((model.size() != 0) ? model[0] : last_val);
    stb_n = 1'b0;
    rd_n  = 1'b1;
    step(4);
    stb_n = 1'b1;
    step(4);
    if (model.size() != 0) void'(model.pop_front());
    model.push_back(d);
    last_val = model[0];
  endtask

  task automatic pulse_ovf_clr();
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    step(1);
    m_ovf = 1'b0;
  endtask

  // Monitor: the CPU latches data_out at the end of each read.
  initial begin
    forever begin
      @(posedge rd_n);
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL read_data: no expectation queued, got %0h", data_out);
        end else begin
          check("read_data", 32'(data_out), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got hang, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] v;
    reset_n = 1'b0;
    mode = 1'b0; port_in = '0; stb_n = 1'b1; rd_n = 1'b1; inte = 1'b0; ovf_clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #7;
      mode    = 1'($urandom);
      port_in = W'($urandom);
      stb_n   = 1'($urandom);
      rd_n    = 1'($urandom);
      inte    = 1'($urandom);
      ovf_clr = 1'($urandom);
      check("reset data_out", 32'(data_out), 32'd0);
    end
    check("reset ibf",       32'(ibf),       32'd0);
    check("reset not_empty", 32'(not_empty), 32'd0);
    check("reset intr",      32'(intr),      32'd0);
    check("reset count",     32'(count),     32'd0);
    check("reset ovf",       32'(ovf),       32'd0);

    step(1);
    mode = 1'b0; port_in = '0; stb_n = 1'b1; rd_n = 1'b1; inte = 1'b0; ovf_clr = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(4);
    port_in = 8'hA5;
    step(2);
    check("mode0 latency early", 32'(data_out), 32'h00);
    step(1);
    check("mode0 latency", 32'(data_out), 32'hA5);

    mode = 1'b1;
    step(4);
    last_val = 8'hA5;
    mon_en = 1'b1;
    chk_flags("idle");

    // single handshake
    inte = 1'b1;
    do_push(8'h3C);
    chk_flags("hs push");
    check("hs data_out", 32'(data_out), 32'h3C);
    do_read();
    chk_flags("hs read");
    check("hs hold", 32'(data_out), 32'h3C);

    // fill and overflow
    for (int i = 1; i <= 5; i++) begin
      do_push(W'(i));
      chk_flags("fill");
    end
    for (int i = 0; i < 4; i++) begin
      do_read();
      chk_flags("drain");
    end
    pulse_ovf_clr();
    chk_flags("ovf_clr");

    // simultaneous push/pop when full and when empty
    for (int i = 0; i < D; i++) do_push(W'($urandom));
    chk_flags("sim pre");
    do_simul(W'($urandom));
    chk_flags("sim full");
    while (model.size() != 0) do_read();
    do_simul(W'($urandom));
    chk_flags("sim empty");
    do_read();

    // wrap-around
    for (int i = 0; i < 10; i++) begin
      do_push(W'(8'h10 + i));
      chk_flags("wrap push");
      do_read();
      chk_flags("wrap read");
    end

    // randomised traffic
    for (int i = 0; i < 80; i++) begin
      int op;
      if ($urandom_range(0, 3) == 0) inte = 1'($urandom);
      op = int'($urandom_range(0, 9));
      if (op < 4)       do_push(W'($urandom));
      else if (op < 8)  do_read();
      else if (op == 8) do_simul(W'($urandom));
      else              pulse_ovf_clr();
      chk_flags("rand");
    end

    // mode change mid-operation
    while (model.size() != 0) do_read();
    for (int i = 0; i < 5; i++) do_push(W'($urandom));
    do_read();
    inte = 1'b1;
    step(2);
    chk_flags("mc pre");
    mode = 1'b0;
    step(1);
    check("mc count", 32'(count), 32'd0);
    check("mc intr",  32'(intr),  32'd0);
    check("mc ovf",   32'(ovf),   32'd0);
    model.delete();
    m_ovf = 1'b0;
    v = W'($urandom);
    port_in = v;
    step(3);
    check("mc track", 32'(data_out), 32'(v));
    mode = 1'b1;
    step(4);
    last_val = v;
    chk_flags("mc back");
    do_read();
    do_push(8'h5A);
    chk_flags("mc push");
    do_read();
    chk_flags("final");

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/port_strobed_in.md
# port_strobed_in

Parametrised input port for the 8255A-compatible peripheral. It replaces the fixed 8-bit port-B input latch with a configurable-width port, a selectable mode and a small receive FIFO. Mode 0 is simple sampled input. Mode 1 is strobed handshake input (STB#/IBF/INTR) with DEPTH-entry buffering. It sits between the external port pins and the CPU-side read mux.

## Interface
- WIDTH, 8, port data width (≥1)
- DEPTH, 4, FIFO entries in mode 1 (power of two, ≥2)
- SYNC_STAGES, 2, synchroniser flops on stb_n, rd_n and port_in (≥2)
- CW, $clog2(DEPTH+1), derived width of `count`
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- mode  in  1  0 = sampled input, 1 = strobed handshake input
- port_in  in  WIDTH  external port data
- stb_n  in  1  peripheral strobe, active low (mode 1 only)
- rd_n  in  1  CPU read strobe for this port, active low
- inte  in  1  interrupt enable (control-word INTE bit)
- ovf_clr  in  1  synchronous clear of `ovf`
- data_out  out  WIDTH  data presented to the CPU read mux
- ibf  out  1  input buffer full, to the peripheral
- not_empty  out  1  FIFO holds ≥1 entry
- intr  out  1  interrupt request
- count  out  CW  FIFO occupancy, 0..DEPTH
- ovf  out  1  sticky: a strobe was dropped because the FIFO was full

## Operation
- **Synchronisation.** stb_n, rd_n and port_in each pass through SYNC_STAGES flops, giving stb_s, rd_s and pin_s. stb_n and rd_n synchroniser flops reset to 1. Edge detectors compare the last stage with one further registered copy.
- **Mode 0.**
  - data_out <= pin_s every clock.
  - FIFO is held empty: count=0, not_empty=0, ibf=0, intr=0.
  - stb_n and inte are ignored.
- **Mode 1, push.** A stb_s falling edge pushes pin_s into the FIFO.
  - If count==DEPTH and no pop occurs that cycle, the data is dropped, ovf is set and FIFO state is unchanged.
- **Mode 1, pop.** A rd_s rising edge (end of CPU read) pops the head.
  - A pop on an empty FIFO is ignored. No underflow, pointers unchanged.
- **Simultaneous push and pop.**
  - Both take effect; count is unchanged.
  - When full, the pop frees the slot and the push is accepted, with no overflow.
  - When empty, the pop is ignored and the push is accepted.
- **data_out in mode 1.**
  - Equals the FIFO head whenever not_empty=1.
  - When the FIFO becomes empty, it holds the last value presented.
- **Status flags.**
  - ibf = (count==DEPTH).
  - not_empty = (count!=0).
  - Both are derived from registered count.
- **intr.** Registered. The next value is inte & not_empty & stb_s & rd_s.
  - It is set only after the strobe has returned high.
  - It drops while a read is in progress (rd_s low).
  - It drops immediately when inte is deasserted.
- **ovf.**
  - Cleared by ovf_clr, reset, or any mode change.
  - If ovf_clr and a new overflow occur in the same cycle, set wins.
- **Mode change.** Any cycle where mode differs from its registered copy flushes the FIFO (pointers and count to 0) and clears ovf and intr. Pending edges in that cycle are discarded.
- **Pointers.** Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is tracked separately so full and empty are unambiguous.

## Timing
- **Reset values** (asynchronous, with reset_n low):
  - data_out=0, ibf=0, not_empty=0, intr=0, count=0, ovf=0.
  - Pointers 0, mode copy 0, stb/rd synchronisers 1, data synchronisers 0.
- **Reset mid-transfer:** all FIFO contents are discarded. The first strobe after release is treated as a fresh push only if a falling edge is seen after the synchronisers fill with 1.
- **Push latency:** stb_n low first sampled at edge E0. The push commits at edge E0+SYNC_STAGES. count, not_empty, ibf and data_out (first entry) update at that edge.
- **Data setup:** port_in must be stable for SYNC_STAGES+1 clocks around the stb_n falling edge, so the same-pipeline-depth sample is the one pushed.
- **Pop latency:** rd_n high first sampled at E0. The pop commits at E0+SYNC_STAGES. data_out shows the next entry after that edge.
- **intr latency:** one clock after its enabling condition holds on synchronised signals.
- **Mode 0 latency:** port_in to data_out is SYNC_STAGES+1 clocks.
- **Minimum strobe spacing:** stb_n low and high widths must each be ≥ SYNC_STAGES+1 clocks. Shorter pulses may be missed.

## Test plan
- **Reset:** hold reset_n=0 with random inputs → all outputs 0. Release, mode=0, port_in=8'hA5 → data_out=8'hA5 exactly 3 clocks later.
- **Single handshake:** mode=1, inte=1, port_in=8'h3C, pulse stb_n low 4 clocks → count=1, data_out=8'h3C, intr=1 after stb_n returns high. Pulse rd_n → intr falls during the read, count=0, data_out holds 8'h3C.
- **Fill and overflow (DEPTH=4):** push 8'h01..8'h05 with no reads → ibf=1 after the 4th push. 5th push dropped, ovf=1. Reads return 01,02,03,04 in order. ovf_clr → ovf=0.
- **Simultaneous:** with count=4, align stb_n fall and rd_n rise to the same synchronised cycle → count stays 4, ovf=0. With count=0 and the same alignment → count=1.
- **Wrap-around:** 10 push/pop pairs of 8'h10..8'h19 → data order preserved across pointer wrap, count never exceeds 1.
- **Mode change mid-operation:** count=3, toggle mode to 0 → count=0, intr=0, ovf=0 next clock, and data_out tracks port_in.
